// File: rtl/front_pipe_regs_if.sv
// Bundle between the hazard unit / datapath and the front-end pipeline registers.
// The master side drives stage codes and stage inputs; the slave side owns the registers.
interface front_pipe_regs_if #(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
);
    logic [1:0]        PCFlush;
    logic [1:0]        IFIDFlush;
    logic [1:0]        IDEXFlush;
    logic [31:0]       pc_next;
    logic [31:0]       if_instr;
    logic [CTRL_W-1:0] id_ctrl;
    logic [31:0]       id_rs_data;
    logic [31:0]       id_rt_data;
    logic [31:0]       id_imm;

    logic [31:0]       PC;
    logic [31:0]       IFID_PC4;
    logic [31:0]       IFID_Instr;
    logic              IFID_Valid;
    logic [CTRL_W-1:0] IDEX_Ctrl;
    logic [31:0]       IDEX_PC4;
    logic [31:0]       IDEX_RsData;
    logic [31:0]       IDEX_RtData;
    logic [31:0]       IDEX_Imm;
    logic [4:0]        IDEXRs;
    logic [4:0]        IDEXRt;
    logic [4:0]        IDEXRd;
    logic              IDEX_Valid;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output PCFlush, IFIDFlush, IDEXFlush,
        output pc_next, if_instr, id_ctrl, id_rs_data, id_rt_data, id_imm,
        input  PC, IFID_PC4, IFID_Instr, IFID_Valid,
        input  IDEX_Ctrl, IDEX_PC4, IDEX_RsData, IDEX_RtData, IDEX_Imm,
        input  IDEXRs, IDEXRt, IDEXRd, IDEX_Valid,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  PCFlush, IFIDFlush, IDEXFlush,
        input  pc_next, if_instr, id_ctrl, id_rs_data, id_rt_data, id_imm,
        output PC, IFID_PC4, IFID_Instr, IFID_Valid,
        output IDEX_Ctrl, IDEX_PC4, IDEX_RsData, IDEX_RtData, IDEX_Imm,
        output IDEXRs, IDEXRt, IDEXRd, IDEX_Valid,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/front_pipe_regs.sv
// PC, IF/ID and ID/EX registers of the 5-stage MIPS core, each steered by its own
// load/bubble/hold code from the hazard unit, plus saturating stall/flush counters.
module front_pipe_regs #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          CTRL_W   = 16,
    parameter int          CNT_W    = 16
) (
    input logic              clk,
    input logic              reset,
    front_pipe_regs_if.slave bus
);

    typedef enum logic [1:0] {
        ACT_LOAD,
        ACT_BUBBLE,
        ACT_HOLD
    } act_e;

    // Code 11 is illegal; it must squash rather than freeze, so only 10 means hold.
    function automatic act_e decode(input logic [1:0] code);
        act_e act;
        unique case (code)
            2'b00:   act = ACT_LOAD;
            2'b10:   act = ACT_HOLD;
            default: act = ACT_BUBBLE;
        endcase
        return act;
    endfunction

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    act_e pc_act;
    act_e ifid_act;
    act_e idex_act;
    logic stall_evt;
    logic flush_evt;

    logic [31:0]       pc_q;
    logic [31:0]       ifid_pc4_q;
    logic [31:0]       ifid_instr_q;
    logic              ifid_valid_q;
    logic [CTRL_W-1:0] idex_ctrl_q;
    logic [31:0]       idex_pc4_q;
    logic [31:0]       idex_rs_data_q;
    logic [31:0]       idex_rt_data_q;
    logic [31:0]       idex_imm_q;
    logic [4:0]        idex_rs_q;
    logic [4:0]        idex_rt_q;
    logic [4:0]        idex_rd_q;
    logic              idex_valid_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        pc_act    = ACT_HOLD;
        ifid_act  = ACT_HOLD;
        idex_act  = ACT_HOLD;
        stall_evt = 1'b0;
        flush_evt = 1'b0;

        pc_act    = decode(bus.PCFlush);
        ifid_act  = decode(bus.IFIDFlush);
        idex_act  = decode(bus.IDEXFlush);
        stall_evt = (bus.PCFlush == 2'b10);
        flush_evt = bus.IFIDFlush[0];
    end

    // The PC has no empty state, so a bubble code leaves it where it is.
    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (pc_act == ACT_LOAD) begin
            pc_q <= bus.pc_next;
        end
    end

    // A bubble in ID is sll $0,$0,0 with a cleared valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_pc4_q   <= '0;
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            unique case (ifid_act)
                ACT_LOAD: begin
                    ifid_pc4_q   <= pc_q + 32'd4;
                    ifid_instr_q <= bus.if_instr;
                    ifid_valid_q <= 1'b1;
                end
                ACT_BUBBLE: begin
                    ifid_pc4_q   <= '0;
                    ifid_instr_q <= '0;
                    ifid_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // A zeroed control bundle in EX cannot write registers, touch memory or branch.
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_ctrl_q    <= '0;
            idex_pc4_q     <= '0;
            idex_rs_data_q <= '0;
            idex_rt_data_q <= '0;
            idex_imm_q     <= '0;
            idex_rs_q      <= '0;
            idex_rt_q      <= '0;
            idex_rd_q      <= '0;
            idex_valid_q   <= 1'b0;
        end else begin
            unique case (idex_act)
                ACT_LOAD: begin
                    idex_ctrl_q    <= bus.id_ctrl;
                    idex_pc4_q     <= ifid_pc4_q;
                    idex_rs_data_q <= bus.id_rs_data;
                    idex_rt_data_q <= bus.id_rt_data;
                    idex_imm_q     <= bus.id_imm;
                    idex_rs_q      <= ifid_instr_q[25:21];
                    idex_rt_q      <= ifid_instr_q[20:16];
                    idex_rd_q      <= ifid_instr_q[15:11];
                    idex_valid_q   <= ifid_valid_q;
                end
                ACT_BUBBLE: begin
                    idex_ctrl_q    <= '0;
                    idex_pc4_q     <= '0;
                    idex_rs_data_q <= '0;
                    idex_rt_data_q <= '0;
                    idex_imm_q     <= '0;
                    idex_rs_q      <= '0;
                    idex_rt_q      <= '0;
                    idex_rd_q      <= '0;
                    idex_valid_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_evt && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_evt && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign bus.PC          = pc_q;
    assign bus.IFID_PC4    = ifid_pc4_q;
    assign bus.IFID_Instr  = ifid_instr_q;
    assign bus.IFID_Valid  = ifid_valid_q;
    assign bus.IDEX_Ctrl   = idex_ctrl_q;
    assign bus.IDEX_PC4    = idex_pc4_q;
    assign bus.IDEX_RsData = idex_rs_data_q;
    assign bus.IDEX_RtData = idex_rt_data_q;
    assign bus.IDEX_Imm    = idex_imm_q;
    assign bus.IDEXRs      = idex_rs_q;
    assign bus.IDEXRt      = idex_rt_q;
    assign bus.IDEXRd      = idex_rd_q;
    assign bus.IDEX_Valid  = idex_valid_q;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_front_pipe_regs.sv
// Directed and randomized checks of front_pipe_regs against a cycle-level model of
// the three pipeline stages and the two event counters.
module tb_front_pipe_regs;

    localparam int          CTRL_W   = 16;
    localparam int          CNT_W    = 4;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    front_pipe_regs_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

    front_pipe_regs #(
        .RESET_PC(RESET_PC),
        .CTRL_W  (CTRL_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    // Architectural view of the front end: what each slot should contain.
    typedef struct {
        logic [31:0]       pc;
        logic [31:0]       id_pc4;
        logic [31:0]       id_instr;
        logic              id_valid;
        logic [CTRL_W-1:0] ex_ctrl;
        logic [31:0]       ex_pc4;
        logic [31:0]       ex_rs_data;
        logic [31:0]       ex_rt_data;
        logic [31:0]       ex_imm;
        logic [4:0]        ex_rs;
        logic [4:0]        ex_rt;
        logic [4:0]        ex_rd;
        logic              ex_valid;
        int                stalls;
        int                flushes;
    } model_t;

    model_t m;
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs presented this cycle.
    task automatic model_step();
        model_t old;
        int     cnt_max;
        logic [31:0] instr;
        old     = m;
        cnt_max = (1 << CNT_W) - 1;
        instr   = old.id_instr;
        if (reset) begin
            m = '{pc: RESET_PC, default: '0};
            return;
        end
        if (bus.PCFlush == 2'd0) m.pc = bus.pc_next;

        if (bus.IFIDFlush == 2'd0) begin
            m.id_pc4   = old.pc + 32'd4;
            m.id_instr = bus.if_instr;
            m.id_valid = 1'b1;
        end else if (bus.IFIDFlush != 2'd2) begin
            m.id_pc4   = 32'd0;
            m.id_instr = 32'd0;
            m.id_valid = 1'b0;
        end

        if (bus.IDEXFlush == 2'd0) begin
            m.ex_ctrl    = bus.id_ctrl;
            m.ex_pc4     = old.id_pc4;
            m.ex_rs_data = bus.id_rs_data;
            m.ex_rt_data = bus.id_rt_data;
            m.ex_imm     = bus.id_imm;
            m.ex_rs      = 5'((instr >> 21) & 32'h1f);
            m.ex_rt      = 5'((instr >> 16) & 32'h1f);
            m.ex_rd      = 5'((instr >> 11) & 32'h1f);
            m.ex_valid   = old.id_valid;
        end else if (bus.IDEXFlush != 2'd2) begin
            m.ex_ctrl    = '0;
            m.ex_pc4     = '0;
            m.ex_rs_data = '0;
            m.ex_rt_data = '0;
            m.ex_imm     = '0;
            m.ex_rs      = '0;
            m.ex_rt      = '0;
            m.ex_rd      = '0;
            m.ex_valid   = 1'b0;
        end

        if (bus.PCFlush == 2'd2)                               m.stalls  = (old.stalls  < cnt_max) ? old.stalls  + 1 : cnt_max;
        if (bus.IFIDFlush == 2'd1 || bus.IFIDFlush == 2'd3)    m.flushes = (old.flushes < cnt_max) ? old.flushes + 1 : cnt_max;
    endtask

    task automatic compare_all();
        check("pc",          bus.PC,                m.pc);
        check("ifid_pc4",    bus.IFID_PC4,          m.id_pc4);
        check("ifid_instr",  bus.IFID_Instr,        m.id_instr);
        check("ifid_valid",  32'(bus.IFID_Valid),   32'(m.id_valid));
        check("idex_ctrl",   32'(bus.IDEX_Ctrl),    32'(m.ex_ctrl));
        check("idex_pc4",    bus.IDEX_PC4,          m.ex_pc4);
        check("idex_rsdata", bus.IDEX_RsData,       m.ex_rs_data);
        check("idex_rtdata", bus.IDEX_RtData,       m.ex_rt_data);
        check("idex_imm",    bus.IDEX_Imm,          m.ex_imm);
        check("idex_rs",     32'(bus.IDEXRs),       32'(m.ex_rs));
        check("idex_rt",     32'(bus.IDEXRt),       32'(m.ex_rt));
        check("idex_rd",     32'(bus.IDEXRd),       32'(m.ex_rd));
        check("idex_valid",  32'(bus.IDEX_Valid),   32'(m.ex_valid));
        check("stall_cnt",   32'(bus.stall_cnt),    32'(m.stalls));
        check("flush_cnt",   32'(bus.flush_cnt),    32'(m.flushes));
    endtask

    task automatic set_codes(input logic [1:0] pc_code, input logic [1:0] ifid_code,
                             input logic [1:0] idex_code);
        bus.PCFlush   = pc_code;
        bus.IFIDFlush = ifid_code;
        bus.IDEXFlush = idex_code;
    endtask

    task automatic random_data();
        bus.pc_next    = $urandom;
        bus.if_instr   = $urandom;
        bus.id_ctrl    = CTRL_W'($urandom);
        bus.id_rs_data = $urandom;
        bus.id_rt_data = $urandom;
        bus.id_imm     = $urandom;
    endtask

    // Inputs change #1 after the edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        logic [31:0] held_instr;
        logic [31:0] fields;

        // Reset held for two cycles with load codes.
        reset = 1'b1;
        set_codes(2'b00, 2'b00, 2'b00);
        random_data();
        tick();
        random_data();
        tick();
        check("rst_pc",        bus.PC,               32'h0040_0000);
        check("rst_ifid",      bus.IFID_Instr,       32'h0);
        check("rst_ctrl",      32'(bus.IDEX_Ctrl),   32'h0);
        check("rst_stall",     32'(bus.stall_cnt),   32'h0);
        check("rst_flush",     32'(bus.flush_cnt),   32'h0);

        // Straight-line fetch of addi $t0,$0,5.
        reset          = 1'b0;
        bus.pc_next    = 32'h0040_0004;
        bus.if_instr   = 32'h2008_0005;
        tick();
        check("sl_pc",         bus.PC,               32'h0040_0004);
        check("sl_ifid_instr", bus.IFID_Instr,       32'h2008_0005);
        check("sl_ifid_pc4",   bus.IFID_PC4,         32'h0040_0004);
        held_instr     = $urandom;
        bus.pc_next    = 32'h0040_0008;
        bus.if_instr   = held_instr;
        tick();
        check("sl_idex_rt",    32'(bus.IDEXRt),      32'd8);
        check("sl_idex_rs",    32'(bus.IDEXRs),      32'd0);
        check("sl_idex_valid", 32'(bus.IDEX_Valid),  32'd1);
        check("sl_idex_pc4",   bus.IDEX_PC4,         32'h0040_0004);

        // Load-use: freeze PC and ID, bubble into EX.
        set_codes(2'b10, 2'b10, 2'b01);
        random_data();
        tick();
        check("lu_pc",         bus.PC,               32'h0040_0008);
        check("lu_ifid_instr", bus.IFID_Instr,       held_instr);
        check("lu_ctrl",       32'(bus.IDEX_Ctrl),   32'h0);
        check("lu_valid",      32'(bus.IDEX_Valid),  32'd0);
        check("lu_stall",      32'(bus.stall_cnt),   32'd1);
        set_codes(2'b00, 2'b00, 2'b00);
        random_data();
        tick();
        fields = held_instr >> 16;
        check("lu_release_rt",    32'(bus.IDEXRt),     fields & 32'h1f);
        check("lu_release_valid", 32'(bus.IDEX_Valid), 32'd1);

        // Taken branch: fetch target, squash both wrong-path slots.
        set_codes(2'b00, 2'b01, 2'b01);
        random_data();
        bus.pc_next = 32'h0040_0040;
        tick();
        check("br_pc",         bus.PC,               32'h0040_0040);
        check("br_ifid_instr", bus.IFID_Instr,       32'h0);
        check("br_ifid_valid", 32'(bus.IFID_Valid),  32'd0);
        check("br_idex_valid", 32'(bus.IDEX_Valid),  32'd0);
        check("br_flush",      32'(bus.flush_cnt),   32'd1);

        // Refill, then illegal 11 on every stage behaves as a bubble; PC holds.
        set_codes(2'b00, 2'b00, 2'b00);
        random_data();
        bus.pc_next = 32'h0040_0044;
        bus.id_ctrl = 16'hbeef;
        tick();
        set_codes(2'b11, 2'b11, 2'b11);
        random_data();
        tick();
        check("il_pc",         bus.PC,               32'h0040_0044);
        check("il_ifid_instr", bus.IFID_Instr,       32'h0);
        check("il_ifid_valid", 32'(bus.IFID_Valid),  32'd0);
        check("il_ctrl",       32'(bus.IDEX_Ctrl),   32'h0);
        check("il_idex_valid", 32'(bus.IDEX_Valid),  32'd0);
        check("il_flush",      32'(bus.flush_cnt),   32'd2);
        check("il_stall",      32'(bus.stall_cnt),   32'd1);

        // Randomized codes and data, with occasional reset.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 31) == 0);
            set_codes(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            random_data();
            tick();
        end

        // Counter saturation over 20 stall cycles, then reset in mid-stall.
        reset = 1'b1;
        set_codes(2'b00, 2'b00, 2'b00);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_codes(2'b10, 2'b00, 2'b00);
            random_data();
            tick();
        end
        check("sat_stall",     32'(bus.stall_cnt),   32'h0000_000f);
        reset = 1'b1;
        set_codes(2'b10, 2'b10, 2'b10);
        random_data();
        tick();
        check("rst_mid_stall", 32'(bus.stall_cnt),   32'd0);
        check("rst_mid_pc",    bus.PC,               32'h0040_0000);
        check("rst_mid_valid", 32'(bus.IFID_Valid),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
